segmented_move_op_handler: RTL

//  Parametrised successor to the dummy op handler. Executes one relative move
//  (dx, dy, pen) per op, using the op-handler handshake (trigger/rdy/done).

---
 rtl/segmented_move_op_handler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/segmented_move_op_handler.sv
// Runs one relative move per op: it sets the servo and waits out the settle time
// when the pen changes, then issues motor commands clamped to MAX_CHUNK pulses per axis.
module segmented_move_op_handler #(
    parameter int POS_W      = 12,
    parameter int PULSE_W    = 10,
    parameter int MAX_CHUNK  = 500,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      op_trigger,
    input  logic signed [POS_W-1:0]   op_dx,
    input  logic signed [POS_W-1:0]   op_dy,
    input  logic                      op_pen_down,
    output logic                      op_rdy,
    output logic                      op_done,
    output logic signed [PULSE_W-1:0] mot_pulse_num_x,
    output logic signed [PULSE_W-1:0] mot_pulse_num_y,
    output logic                      mot_servo_pos,
    output logic                      mot_trigger,
    input  logic                      mot_rdy,
    input  logic                      mot_done
);

    localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic signed [POS_W-1:0] MAX_P = POS_W'(MAX_CHUNK);

    typedef enum logic [2:0] {
        S_IDLE, S_SERVO, S_SETTLE, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic signed [POS_W-1:0]    rem_x_reg, rem_x_next;
    logic signed [POS_W-1:0]    rem_y_reg, rem_y_next;
    logic                       pen_reg, pen_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       servo_reg, servo_next;
    logic signed [PULSE_W-1:0]  px_reg, px_next;
    logic signed [PULSE_W-1:0]  py_reg, py_next;
    logic                       trig_reg, trig_next;
    logic                       done_reg, done_next;
    logic                       rdy_reg, rdy_next;
    logic signed [POS_W-1:0]    cx, cy;

    function automatic logic signed [POS_W-1:0] clamp(input logic signed [POS_W-1:0] v);
        if (v > MAX_P)
            return MAX_P;
        else if (v < -MAX_P)
            return -MAX_P;
        else
            return v;
    endfunction

    assign cx = clamp(rem_x_reg);
    assign cy = clamp(rem_y_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            rem_x_reg <= '0;
            rem_y_reg <= '0;
            pen_reg   <= 1'b0;
            cnt_reg   <= '0;
            servo_reg <= 1'b0;
            px_reg    <= '0;
            py_reg    <= '0;
            trig_reg  <= 1'b0;
            done_reg  <= 1'b0;
            rdy_reg   <= 1'b1;
        end else if (clk_en) begin
            state_reg <= state_next;
            rem_x_reg <= rem_x_next;
            rem_y_reg <= rem_y_next;
            pen_reg   <= pen_next;
            cnt_reg   <= cnt_next;
            servo_reg <= servo_next;
            px_reg    <= px_next;
            py_reg    <= py_next;
            trig_reg  <= trig_next;
            done_reg  <= done_next;
            rdy_reg   <= rdy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_x_next = rem_x_reg;
        rem_y_next = rem_y_reg;
        pen_next   = pen_reg;
        cnt_next   = cnt_reg;
        servo_next = servo_reg;
        px_next    = px_reg;
        py_next    = py_reg;
        trig_next  = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (op_trigger) begin
                    rem_x_next = op_dx;
                    rem_y_next = op_dy;
                    pen_next   = op_pen_down;
                    state_next = (op_pen_down != servo_reg) ? S_SERVO : S_ISSUE;
                end
            end
            S_SERVO: begin
                servo_next = pen_reg;
                cnt_next   = CNT_W'(SETTLE_CYC);
                state_next = (SETTLE_CYC == 0) ? S_ISSUE : S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_reg == '0)
                    state_next = S_ISSUE;
                else
                    cnt_next = cnt_reg - CNT_W'(1);
            end
            S_ISSUE: begin
                if (rem_x_reg == '0 && rem_y_reg == '0) begin
                    state_next = S_DONE;
                end else if (mot_rdy) begin
                    // Each axis clamps on its own; rem only shrinks toward zero.
                    px_next    = PULSE_W'(cx);
                    py_next    = PULSE_W'(cy);
                    rem_x_next = rem_x_reg - cx;
                    rem_y_next = rem_y_reg - cy;
                    trig_next  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mot_done)
                    state_next = S_ISSUE;
            end
            S_DONE: begin
                done_next  = 1'b1;
                px_next    = '0;
                py_next    = '0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        rdy_next = (state_next == S_IDLE);
    end

    always_comb begin
        op_rdy          = rdy_reg;
        op_done         = done_reg;
        mot_pulse_num_x = px_reg;
        mot_pulse_num_y = py_reg;
        mot_servo_pos   = servo_reg;
        mot_trigger     = trig_reg;
    end

endmodule
